// File: rtl/writeback_regfile.sv
// Write-back stage and architectural register file for the sequential Y86-64 core.
// Optional macro WB_BYPASS_EN adds two read ports that forward same-cycle commit data.
module writeback_regfile #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic [3:0]              icode,
    input  logic                    cnd,
    input  logic [3:0]              rA,
    input  logic [3:0]              rB,
    input  logic [DATA_W-1:0]       valE,
    input  logic [DATA_W-1:0]       valM,
    input  logic [2:0]              stat_in,
`ifdef WB_BYPASS_EN
    input  logic [3:0]              srcA,
    input  logic [3:0]              srcB,
    output logic [DATA_W-1:0]       rdA,
    output logic [DATA_W-1:0]       rdB,
`endif
    output logic [NREGS*DATA_W-1:0] regs_out,
    output logic [2:0]              stat_out,
    output logic                    halted,
    output logic [CNT_W-1:0]        retired
);

    // state  | meaning
    // S_RUN  | committing retiring instructions
    // S_HALT | halt or fault seen; everything frozen until rst
    typedef enum logic {S_RUN, S_HALT} state_t;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] regs [NREGS];
    logic [3:0]        dst_e, dst_m;
    logic              commit, fault;

    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (icode)
            4'h2:                    dst_e = cnd ? rB : RNONE;
            4'h3, 4'h6:              dst_e = rB;
            4'h8, 4'h9, 4'hA, 4'hB:  dst_e = 4'h4;
            default:                 dst_e = RNONE;
        endcase
        case (icode)
            4'h5, 4'hB: dst_m = rA;
            default:    dst_m = RNONE;
        endcase
    end

    assign commit = (state == S_RUN) && valid && (stat_in == STAT_AOK) && (icode != 4'h0);
    assign fault  = (state == S_RUN) && valid && ((stat_in != STAT_AOK) || (icode == 4'h0));

    always_comb begin
        state_nxt = state;
        if (fault) state_nxt = S_HALT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RUN;
        else     state <= state_nxt;
    end

    // valM is checked first so popq %rsp keeps the popped value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < NREGS; i++) begin
                if (dst_m == 4'(i))      regs[i] <= valM;
                else if (dst_e == 4'(i)) regs[i] <= valE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_out <= STAT_AOK;
            retired  <= '0;
        end else if (fault) begin
            stat_out <= (icode == 4'h0) ? STAT_HLT : stat_in;
        end else if (commit) begin
            retired  <= retired + CNT_W'(1);
        end
    end

    assign halted = (state == S_HALT);

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_out[g*DATA_W +: DATA_W] = regs[g];
    end

`ifdef WB_BYPASS_EN
    function automatic logic [DATA_W-1:0] read_port(input logic [3:0] src);
        logic [DATA_W-1:0] rd;
        rd = '0;
        for (int i = 0; i < NREGS; i++)
            if (src == 4'(i)) rd = regs[i];
        if (src == RNONE)                      rd = '0;
        else if (commit && (src == dst_m))     rd = valM;
        else if (commit && (src == dst_e))     rd = valE;
        return rd;
    endfunction

    always_comb begin
        rdA = read_port(srcA);
        rdB = read_port(srcB);
    end
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile; bypass checks build only with WB_BYPASS_EN.
module tb_writeback_regfile;

    localparam int DW = 64;
    localparam int NR = 15;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           valid;
    logic [3:0]     icode, rA, rB;
    logic           cnd;
    logic [DW-1:0]  valE, valM;
    logic [2:0]     stat_in;
    logic [NR*DW-1:0] regs_out;
    logic [2:0]     stat_out;
    logic           halted;
    logic [CW-1:0]  retired;
`ifdef WB_BYPASS_EN
    logic [3:0]     srcA, srcB;
    logic [DW-1:0]  rdA, rdB;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    writeback_regfile #(.DATA_W(DW), .NREGS(NR), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .valid(valid), .icode(icode), .cnd(cnd),
        .rA(rA), .rB(rB), .valE(valE), .valM(valM), .stat_in(stat_in),
`ifdef WB_BYPASS_EN
        .srcA(srcA), .srcB(srcB), .rdA(rdA), .rdB(rdB),
`endif
        .regs_out(regs_out), .stat_out(stat_out), .halted(halted), .retired(retired)
    );

    function automatic logic [DW-1:0] r(input int i);
        return regs_out[i*DW +: DW];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] a,
                         input logic [3:0] b, input logic [DW-1:0] e, input logic [DW-1:0] m,
                         input logic c, input logic [2:0] st);
        valid = v; icode = ic; rA = a; rB = b; valE = e; valM = m; cnd = c; stat_in = st;
    endtask

    // drive at negedge, let one posedge commit, return at the next negedge
    task automatic step(input logic v, input logic [3:0] ic, input logic [3:0] a,
                        input logic [3:0] b, input logic [DW-1:0] e, input logic [DW-1:0] m,
                        input logic c, input logic [2:0] st);
        drive(v, ic, a, b, e, m, c, st);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0, 4'h1, 4'hF, 4'hF, '0, '0, 1'b0, 3'd1);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic all_zero;
        rst = 1'b1;
        drive(1'b0, 4'h1, 4'hF, 4'hF, '0, '0, 1'b0, 3'd1);
`ifdef WB_BYPASS_EN
        srcA = 4'hF; srcB = 4'hF;
`endif
        @(negedge clk);
        rst = 1'b0;
        chk("rst_regs", DW'(regs_out == '0), DW'(1));
        chk("rst_stat", DW'(stat_out), DW'(1));
        chk("rst_halted", DW'(halted), DW'(0));
        chk("rst_retired", DW'(retired), DW'(0));

        // irmovq into R2
        step(1'b1, 4'h3, 4'hF, 4'h2, 64'h1234, '0, 1'b0, 3'd1);
        chk("irmovq_r2", r(2), 64'h1234);
        chk("irmovq_ret", DW'(retired), DW'(1));

        // R3=5, then asynchronous reset between edges
        step(1'b1, 4'h3, 4'hF, 4'h3, 64'h5, '0, 1'b0, 3'd1);
        chk("pre_rst_r3", r(3), 64'h5);
        drive(1'b1, 4'h3, 4'hF, 4'h3, 64'h77, '0, 1'b0, 3'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_regs", DW'(regs_out == '0), DW'(1));
        chk("midrst_stat", DW'(stat_out), DW'(1));
        chk("midrst_retired", DW'(retired), DW'(0));
        rst = 1'b0;
        drive(1'b0, 4'h1, 4'hF, 4'hF, '0, '0, 1'b0, 3'd1);
        @(negedge clk);

        // cmovXX gated by cnd
        step(1'b1, 4'h2, 4'h1, 4'h6, 64'h7, '0, 1'b0, 3'd1);
        chk("cmov_nc_r6", r(6), 64'h0);
        chk("cmov_nc_ret", DW'(retired), DW'(1));
        step(1'b1, 4'h2, 4'h1, 4'h6, 64'h7, '0, 1'b1, 3'd1);
        chk("cmov_c_r6", r(6), 64'h7);
        chk("cmov_c_ret", DW'(retired), DW'(2));

        // OPq, mrmovq (dstE none), pushq
        step(1'b1, 4'h6, 4'h2, 4'h1, 64'h55, '0, 1'b0, 3'd1);
        chk("opq_r1", r(1), 64'h55);
        step(1'b1, 4'h5, 4'h7, 4'h8, 64'h3333, 64'hAA, 1'b0, 3'd1);
        chk("mrmov_r7", r(7), 64'hAA);
        chk("mrmov_r8", r(8), 64'h0);
        step(1'b1, 4'hA, 4'h7, 4'hF, 64'h100, 64'h0, 1'b0, 3'd1);
        chk("push_r4", r(4), 64'h100);
        chk("push_ret", DW'(retired), DW'(5));

        // popq %rsp: valM beats valE
        step(1'b1, 4'hB, 4'h4, 4'hF, 64'h108, 64'hBEEF, 1'b0, 3'd1);
        chk("poprsp_r4", r(4), 64'hBEEF);
        step(1'b1, 4'hB, 4'h9, 4'hF, 64'hF8, 64'h77, 1'b0, 3'd1);
        chk("pop_r9", r(9), 64'h77);
        chk("pop_r4", r(4), 64'hF8);
        chk("pop_ret", DW'(retired), DW'(7));

        // valid=0 leaves state; rB=F commits without writing
        step(1'b0, 4'h3, 4'hF, 4'hA, 64'hDEAD, '0, 1'b0, 3'd1);
        chk("idle_r10", r(10), 64'h0);
        chk("idle_ret", DW'(retired), DW'(7));
        step(1'b1, 4'h3, 4'hF, 4'hF, 64'hDEAD, '0, 1'b0, 3'd1);
        chk("rnone_ret", DW'(retired), DW'(8));
        chk("rnone_r14", r(14), 64'h0);

        // ADR fault halts and freezes
        step(1'b1, 4'h5, 4'h1, 4'hF, 64'h0, 64'h99, 1'b0, 3'd3);
        chk("adr_r1", r(1), 64'h55);
        chk("adr_stat", DW'(stat_out), DW'(3));
        chk("adr_halted", DW'(halted), DW'(1));
        chk("adr_ret", DW'(retired), DW'(8));
        step(1'b1, 4'h3, 4'hF, 4'h1, 64'h66, '0, 1'b0, 3'd1);
        chk("frozen_r1", r(1), 64'h55);
        chk("frozen_ret", DW'(retired), DW'(8));
        chk("frozen_stat", DW'(stat_out), DW'(3));

        // halt instruction
        do_reset();
        step(1'b1, 4'h0, 4'hF, 4'hF, '0, '0, 1'b0, 3'd1);
        chk("hlt_stat", DW'(stat_out), DW'(2));
        chk("hlt_halted", DW'(halted), DW'(1));
        chk("hlt_ret", DW'(retired), DW'(0));

        // retired counter wrap
        do_reset();
        for (int n = 0; n < 65535; n++)
            step(1'b1, 4'h1, 4'hF, 4'hF, '0, '0, 1'b0, 3'd1);
        chk("wrap_pre", DW'(retired), DW'(16'hFFFF));
        step(1'b1, 4'h1, 4'hF, 4'hF, '0, '0, 1'b0, 3'd1);
        chk("wrap_post", DW'(retired), DW'(0));
        all_zero = (regs_out == '0);
        chk("wrap_regs", DW'(all_zero), DW'(1));
        chk("wrap_halted", DW'(halted), DW'(0));

`ifdef WB_BYPASS_EN
        drive(1'b1, 4'h3, 4'hF, 4'h5, 64'h9, '0, 1'b0, 3'd1);
        srcA = 4'h5; srcB = 4'hF;
        #1;
        chk("byp_rdA", rdA, 64'h9);
        chk("byp_rdB", rdB, 64'h0);
        @(posedge clk); @(negedge clk);
        drive(1'b1, 4'hB, 4'h4, 4'hF, 64'h200, 64'hCAFE, 1'b0, 3'd1);
        srcA = 4'h4; srcB = 4'h5;
        #1;
        chk("byp_pop_rdA", rdA, 64'hCAFE);
        chk("byp_reg_rdB", rdB, 64'h9);
        @(posedge clk); @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
